// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: glitch-filtered start detect, optional parity, 1/2 stop bits,
// per-word error pulses and a first-word-fall-through FIFO. Define UART_RX_BREAK_EN for break detection.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          break_det
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = $clog2(DATA_BITS);
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 1;

  localparam logic [CW-1:0]   LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALFM1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]   BLAST  = BW'(DATA_BITS - 1);
  localparam logic            SLAST  = (STOP_BITS == 2);
  localparam logic [CNTW-1:0] FULL_N = CNTW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic                 meta_q, rs_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_BREAK_EN
  logic                 par_bit_q, par_bit_d;
  logic                 break_q, break_d;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CNTW-1:0]      count_q, count_d;
  logic [DATA_BITS-1:0] head_q, head_d;
  logic                 push, pop, full, sample;

  assign pop    = (count_q != '0) && rx_ready;
  assign full   = (count_q == FULL_N);
  assign sample = (cnt_q == LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = sample ? '0 : cnt_q + CW'(1);
    bit_d        = bit_q;
    stop_d       = stop_q;
    shreg_d      = shreg_q;
    par_err_d    = par_err_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    push         = 1'b0;
`ifdef UART_RX_BREAK_EN
    par_bit_d    = par_bit_q;
    break_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_d     = '0;
        stop_d    = 1'b0;
        par_err_d = 1'b0;
        if (!rs_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALFM1) begin
          cnt_d   = '0;
          state_d = rs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_d = {rs_q, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == BLAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_err_d = (PARITY == 1) ? ~(^shreg_q ^ rs_q) : (^shreg_q ^ rs_q);
`ifdef UART_RX_BREAK_EN
          par_bit_d = rs_q;
`endif
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (!rs_q) begin
`ifdef UART_RX_BREAK_EN
            // All-zero frame through the first stop bit is a line break, not a framing error
            if (shreg_q == '0 && (PARITY == 0 || !par_bit_q) && !stop_q) break_d = 1'b1;
            else frame_err_d = 1'b1;
`else
            frame_err_d = 1'b1;
`endif
            state_d = S_WAIT_HIGH;
          end else if (stop_q == SLAST) begin
            state_d = S_IDLE;
            if (par_err_q)         parity_err_d = 1'b1;
            else if (full && !pop) overrun_d    = 1'b1;
            else                   push         = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Head register keeps the last popped word visible once the FIFO drains
  always_comb begin
    rd_next  = rd_ptr_q + PW'(1);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNTW'(1);
    if (pop && !push) count_d = count_q - CNTW'(1);
    head_d = head_q;
    if (pop && count_q > CNTW'(1))
      head_d = mem_q[rd_next];
    else if (push && (count_q == '0 || (pop && count_q == CNTW'(1))))
      head_d = shreg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q       <= 1'b1;
      rs_q         <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shreg_q      <= '0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
    end else begin
      meta_q       <= rx;
      rs_q         <= meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shreg_q      <= shreg_d;
      par_err_q    <= par_err_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shreg_q;
  end

`ifdef UART_RX_BREAK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      break_q   <= break_d;
    end
  end
  assign break_det = break_q;
`else
  assign break_det = 1'b0;
`endif

  assign rx_data    = head_q;
  assign rx_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the single-byte serial receiver; feeds the CPU's memory-mapped UART register block.
- Supports configurable baud divisor, data width, parity and stop bits, with start-bit glitch rejection.
- Adds per-word error reporting and a small first-word-fall-through FIFO drained by a valid/ready handshake.
- No tri-stated data outputs.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit (115200 baud at 100 MHz); legal range 8..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rx  in  1  asynchronous serial line; idles high
- rx_data  out  DATA_BITS  FIFO head word; LSB is the first bit received
- rx_valid  out  1  FIFO non-empty; rx_data is valid
- rx_ready  in  1  consumer accepts the head word when rx_valid && rx_ready
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch
- overrun  out  1  one-cycle pulse: good word dropped because the FIFO was full
- break_det  out  1  one-cycle pulse: break condition (see Optional Feature)

Behaviour:
- Reset: state IDLE; counters 0; FIFO empty; rx_data 0; rx_valid 0; fifo_count 0; all pulse outputs 0. Synchronizer flops reset to 1.
- Synchronizer: rx passes through 2 flops. All decisions use the synced signal rs, which lags rx by 2 cycles.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps. The half-bit point is CLKS_PER_BIT/2 (integer divide).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: when rs==0, clear the counter and go to START.
- START: at count CLKS_PER_BIT/2-1, re-sample rs.
  - rs==1: false start; return to IDLE with no pulse.
  - rs==0: clear the counter and go to DATA.
- DATA: sample rs when count==CLKS_PER_BIT-1, i.e. at mid-bit.
  - Shift LSB-first into a DATA_BITS shift register.
  - After DATA_BITS samples, go to PARITY if PARITY!=0, else to STOP.
- PARITY: sample one bit mid-bit.
  - Odd: XOR of data bits and parity bit must be 1. Even: it must be 0.
  - Record any mismatch internally; go to STOP.
- STOP: sample STOP_BITS bits mid-bit.
  - Any stop bit sampled 0: assert frame_err for 1 cycle, discard the word, go to WAIT_HIGH.
  - All stop bits 1: go to IDLE in the same cycle as the final stop sample. In that cycle, exactly one of:
    - parity mismatch recorded: assert parity_err, discard the word;
    - else FIFO full and no pop this cycle: assert overrun, drop the word;
    - else push the word.
- WAIT_HIGH: stay until rs==1, then go to IDLE. This prevents the low stop bit from retriggering a start.
- Priority: frame_err suppresses parity_err and overrun for the same frame. At most one error pulse per frame.
- Push latency: the word is visible at rx_data, with rx_valid=1, on the cycle after the final stop sample.
- FIFO read/write: pop on rx_valid && rx_ready. Push and pop in the same cycle:
  - when full: both occur; no overrun; count unchanged;
  - when empty: the push occurs; rx_valid rises next cycle.
- FIFO pointers: wrap modulo FIFO_DEPTH. fifo_count is exact and never exceeds FIFO_DEPTH.
- FIFO output: rx_data holds its value while rx_valid && !rx_ready. When empty, rx_data holds the last popped value and rx_valid is 0.
- Reset mid-frame: the partial frame is discarded with no pulses. The receiver re-arms in IDLE and waits for rs==0.

Optional Feature:
- Macro: UART_RX_BREAK_EN.
- Defined: a frame with all data bits 0, parity bit (if any) 0 and first stop bit 0 is a break, not a framing error.
  - break_det pulses 1 cycle instead of frame_err; parity is not checked; nothing is pushed.
  - FSM then goes to WAIT_HIGH.
- Undefined: break_det is tied to 0; such a frame reports frame_err as normal.

Test Plan:
1. CLKS_PER_BIT=16, 8N1: send 0xA5 then 0x3C with rx_ready=1 -> rx_valid pulses twice with rx_data 0xA5 then 0x3C; no error pulses.
2. PARITY=2 (even): send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first word delivered as 0x07; second produces parity_err=1 for 1 cycle and nothing is pushed; fifo_count stays 0 after the first word is popped.
3. FIFO_DEPTH=4, rx_ready=0: send 0x01..0x05 -> fifo_count=4, rx_data=0x01, overrun pulses once at the fifth frame; then assert rx_ready -> words 0x01..0x04 are popped in order.
4. rx low for 5 cycles (less than CLKS_PER_BIT/2) then high -> no state change beyond START, no pulses, fifo_count 0. Then send 0x55 with its stop bit forced low -> frame_err pulses, nothing pushed, FSM in WAIT_HIGH until rx returns high.
5. Assert rst during data bit 4 of frame 0xFF -> all outputs return to reset values; the next clean frame 0x81 is received correctly.
6. With UART_RX_BREAK_EN: hold rx low for 12 bit times -> break_det pulses once, frame_err stays 0. Without the macro -> frame_err pulses once.
